// File: rtl/ysyx_24080014_lsu_if.sv
// Bus bundle around the load/store unit: execute-side request, memory
// request/response port and writeback-side result.
// The slave modport is the LSU's view; the master modport is the view of the
// surrounding pipeline/memory that drives the LSU.
interface ysyx_24080014_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // execute -> LSU
  logic              in_valid;
  logic              in_ready;
  logic              in_load;
  logic              in_store;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [1:0]        in_size;
  logic              in_sign;
  logic [4:0]        in_rd;

  // LSU <-> memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  // LSU -> writeback
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic [4:0]        out_rd;
  logic              out_misalign;

  modport slave (
    input  in_valid, in_load, in_store, in_addr, in_wdata, in_size, in_sign, in_rd,
    output in_ready,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output out_valid, out_rdata, out_rd, out_misalign,
    input  out_ready
  );

  modport master (
    output in_valid, in_load, in_store, in_addr, in_wdata, in_size, in_sign, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  out_valid, out_rdata, out_rd, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/ysyx_24080014_lsu.sv
// Multi-cycle load/store unit: accepts one operation from execute, checks
// alignment, issues a single word-aligned memory request with byte strobes,
// waits for the response and hands the extended load result to writeback.
// Every output comes from a register or from the state register.
// Only DATA_W = 32 is supported (four byte lanes).
module ysyx_24080014_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_24080014_lsu_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]        req_wmask_q, req_wmask_d;
  logic              req_wen_q, req_wen_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic              load_q, load_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  // Decode of the incoming operation (only used on the accept cycle).
  logic              is_mem;
  logic              bad_align;
  logic [4:0]        in_shamt;
  logic [3:0]        lane_mask;

  // Lane extraction of the returned read word.
  logic [4:0]        rsp_shamt;
  logic [DATA_W-1:0] rsp_shifted;
  logic [DATA_W-1:0] load_result;

  // Decode alignment, lane strobes and shift for the operation at the input.
  always_comb begin
    is_mem    = bus.in_load | bus.in_store;
    bad_align = (bus.in_size == 2'd3) ||
                ((bus.in_size == 2'd1) && bus.in_addr[0]) ||
                ((bus.in_size == 2'd2) && (bus.in_addr[1:0] != 2'b00));
    in_shamt  = {bus.in_addr[1:0], 3'b000};
    case (bus.in_size)
      2'd0:    lane_mask = 4'b0001 << bus.in_addr[1:0];
      2'd1:    lane_mask = 4'b0011 << bus.in_addr[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  // Shift the read word down to the addressed lane and zero/sign-extend it.
  always_comb begin
    rsp_shamt   = {off_q, 3'b000};
    rsp_shifted = bus.mem_rsp_rdata >> rsp_shamt;
    case (size_q)
      2'd0:    load_result = {{(DATA_W-8){sign_q & rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'd1:    load_result = {{(DATA_W-16){sign_q & rsp_shifted[15]}}, rsp_shifted[15:0]};
      default: load_result = rsp_shifted;
    endcase
  end

  // Next-state logic and next values of all latched operation fields.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    req_wen_d   = req_wen_q;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    load_d      = load_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          off_d       = bus.in_addr[1:0];
          size_d      = bus.in_size;
          sign_d      = bus.in_sign;
          load_d      = bus.in_load;
          rd_d        = bus.in_rd;
          rdata_d     = '0;
          // A fault is only meaningful for an actual memory access.
          misalign_d  = is_mem & bad_align;
          req_addr_d  = {bus.in_addr[ADDR_W-1:2], 2'b00};
          req_wdata_d = bus.in_wdata << in_shamt;
          req_wen_d   = bus.in_store & ~bad_align;
          req_wmask_d = (bus.in_store & ~bad_align) ? lane_mask : 4'b0000;
          if (is_mem && !bad_align) begin
            state_d = S_REQ;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rdata_d = load_q ? load_result : '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operation registers; reset clears every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= 4'b0000;
      req_wen_q   <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      load_q      <= 1'b0;
      rd_q        <= 5'd0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      req_wen_q   <= req_wen_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.out_valid     = (state_q == S_RESP);
  assign bus.out_rdata     = rdata_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_misalign  = misalign_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for the load/store unit: hand-computed expected values for
// loads, stores, faults, backpressure, stray responses and mid-op reset.
module tb_ysyx_24080014_lsu;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ysyx_24080014_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  ysyx_24080014_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle; LSU must be idle.
  task automatic accept(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic sg, input logic [4:0] rd);
    check("accept_in_ready", bus_if.in_ready, 1);
    bus_if.in_load  = ld;
    bus_if.in_store = st;
    bus_if.in_addr  = addr;
    bus_if.in_wdata = wdata;
    bus_if.in_size  = size;
    bus_if.in_sign  = sg;
    bus_if.in_rd    = rd;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  // Called the cycle after acceptance: check the request, stall, handshake,
  // then answer with one response pulse in WAIT.
  task automatic mem_serve(input logic [31:0] exp_addr, input logic exp_wen,
                           input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                           input int stall, input logic [31:0] rdata);
    check("req_valid", bus_if.mem_req_valid, 1);
    check("req_addr", bus_if.mem_req_addr, exp_addr);
    check("req_wen", bus_if.mem_req_wen, exp_wen);
    check("req_wmask", bus_if.mem_req_wmask, exp_mask);
    if (exp_wen) check("req_wdata", bus_if.mem_req_wdata, exp_wdata);
    for (int i = 0; i < stall; i++) begin
      bus_if.mem_req_ready = 1'b0;
      tick();
      check("stall_req_valid", bus_if.mem_req_valid, 1);
      check("stall_req_addr", bus_if.mem_req_addr, exp_addr);
      check("stall_req_wmask", bus_if.mem_req_wmask, exp_mask);
      check("stall_req_wen", bus_if.mem_req_wen, exp_wen);
      check("stall_in_ready", bus_if.in_ready, 0);
    end
    bus_if.mem_req_ready = 1'b1;
    tick();
    bus_if.mem_req_ready = 1'b0;
    check("wait_req_dropped", bus_if.mem_req_valid, 0);
    check("wait_no_out", bus_if.out_valid, 0);
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_rdata = rdata;
    tick();
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_rdata = 32'h0;
  endtask

  // Check the result, optionally hold it under backpressure, then retire it.
  task automatic wb_take(input string name, input logic [31:0] exp_rdata,
                         input logic [4:0] exp_rd, input logic exp_mis, input int stall);
    check({name, "_out_valid"}, bus_if.out_valid, 1);
    check({name, "_out_rdata"}, bus_if.out_rdata, exp_rdata);
    check({name, "_out_rd"}, bus_if.out_rd, {27'd0, exp_rd});
    check({name, "_out_misalign"}, bus_if.out_misalign, exp_mis);
    check({name, "_in_ready_busy"}, bus_if.in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      bus_if.out_ready = 1'b0;
      tick();
      check({name, "_hold_valid"}, bus_if.out_valid, 1);
      check({name, "_hold_rdata"}, bus_if.out_rdata, exp_rdata);
      check({name, "_hold_rd"}, bus_if.out_rd, {27'd0, exp_rd});
      check({name, "_hold_in_ready"}, bus_if.in_ready, 0);
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check({name, "_retired"}, bus_if.out_valid, 0);
    check({name, "_idle"}, bus_if.in_ready, 1);
    $display("txn %s: rdata=0x%08h rd=%0d misalign=%0b", name, bus_if.out_rdata,
             bus_if.out_rd, bus_if.out_misalign);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n                = 1'b0;
    bus_if.in_valid      = 1'b0;
    bus_if.in_load       = 1'b0;
    bus_if.in_store      = 1'b0;
    bus_if.in_addr       = 32'h0;
    bus_if.in_wdata      = 32'h0;
    bus_if.in_size       = 2'd0;
    bus_if.in_sign       = 1'b0;
    bus_if.in_rd         = 5'd0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_rdata = 32'h0;
    bus_if.out_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_req_valid", bus_if.mem_req_valid, 0);
    check("rst_req_addr", bus_if.mem_req_addr, 0);
    check("rst_req_wmask", bus_if.mem_req_wmask, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_rdata", bus_if.out_rdata, 0);
    rst_n = 1'b1;
    tick();

    // lb 0x80000003 signed, word 0x807060F0 -> byte 0x80
    accept(1'b1, 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 5'd1);
    mem_serve(32'h8000_0000, 1'b0, 4'b0000, 32'h0, 0, 32'h8070_60F0);
    wb_take("lb", 32'hFFFF_FF80, 5'd1, 1'b0, 0);

    // lbu same address
    accept(1'b1, 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 5'd2);
    mem_serve(32'h8000_0000, 1'b0, 4'b0000, 32'h0, 0, 32'h8070_60F0);
    wb_take("lbu", 32'h0000_0080, 5'd2, 1'b0, 0);

    // lhu 0x80000000 -> 0x60F0
    accept(1'b1, 1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b0, 5'd5);
    mem_serve(32'h8000_0000, 1'b0, 4'b0000, 32'h0, 0, 32'h8070_60F0);
    wb_take("lhu", 32'h0000_60F0, 5'd5, 1'b0, 0);

    // sh 0x80000002: upper half lanes, data shifted by 16
    accept(1'b0, 1'b1, 32'h8000_0002, 32'h1234_BEEF, 2'd1, 1'b0, 5'd6);
    mem_serve(32'h8000_0000, 1'b1, 4'b1100, 32'hBEEF_0000, 0, 32'hFFFF_FFFF);
    wb_take("sh", 32'h0, 5'd6, 1'b0, 0);

    // sb 0x80000001: lane 1
    accept(1'b0, 1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0, 5'd8);
    mem_serve(32'h8000_0000, 1'b1, 4'b0010, 32'h0000_AB00, 0, 32'h0);
    wb_take("sb", 32'h0, 5'd8, 1'b0, 0);

    // Misaligned lw: no memory request, fault result next cycle
    accept(1'b1, 1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 5'd3);
    check("mis_no_req", bus_if.mem_req_valid, 0);
    wb_take("lw_mis", 32'h0, 5'd3, 1'b1, 0);
    check("mis_no_req_after", bus_if.mem_req_valid, 0);

    // Non-memory op passes straight through with zero data
    accept(1'b0, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 5'd4);
    check("nop_no_req", bus_if.mem_req_valid, 0);
    wb_take("nonmem", 32'h0, 5'd4, 1'b0, 0);

    // Backpressure on both sides: lh 0x80000002 signed, word 0x80011234
    accept(1'b1, 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 5'd11);
    mem_serve(32'h8000_0000, 1'b0, 4'b0000, 32'h0, 3, 32'h8001_1234);
    wb_take("lh_bp", 32'hFFFF_8001, 5'd11, 1'b0, 4);

    // Stray responses in IDLE and in REQ are ignored
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_rdata = 32'hBAD0_0001;
    tick();
    bus_if.mem_rsp_valid = 1'b0;
    check("stray_idle_out", bus_if.out_valid, 0);
    check("stray_idle_ready", bus_if.in_ready, 1);
    accept(1'b1, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 5'd7);
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_rdata = 32'hBAD0_0002;
    tick();
    bus_if.mem_rsp_valid = 1'b0;
    check("stray_req_still_req", bus_if.mem_req_valid, 1);
    check("stray_req_out", bus_if.out_valid, 0);
    mem_serve(32'h8000_0008, 1'b0, 4'b0000, 32'h0, 0, 32'h1122_3344);
    wb_take("lw_stray", 32'h1122_3344, 5'd7, 1'b0, 0);

    // Reset during WAIT
    accept(1'b1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 5'd9);
    check("rw_req_valid", bus_if.mem_req_valid, 1);
    bus_if.mem_req_ready = 1'b1;
    tick();
    bus_if.mem_req_ready = 1'b0;
    check("rw_in_wait", bus_if.mem_req_valid, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rw_req_addr", bus_if.mem_req_addr, 0);
    check("rw_out_rd", bus_if.out_rd, 0);
    check("rw_in_ready", bus_if.in_ready, 1);
    check("rw_out_valid", bus_if.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_rdata = 32'hBAD0_0003;
    tick();
    bus_if.mem_rsp_valid = 1'b0;
    check("rw_late_rsp_out", bus_if.out_valid, 0);
    check("rw_late_rsp_idle", bus_if.in_ready, 1);
    accept(1'b1, 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 5'd10);
    mem_serve(32'h8000_0004, 1'b0, 4'b0000, 32'h0, 0, 32'hDEAD_BEEF);
    wb_take("lw_after_rst", 32'hDEAD_BEEF, 5'd10, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
